// File: rtl/mmu_pkg.sv
// Shared types and constants for the instruction-fetch translation stage.
// Segment decode follows the MIPS32 fixed memory map.
package mmu_pkg;

  typedef enum logic [2:0] {
    XLATE,
    REQ,
    RESP,
    OUT,
    EXC,
    HALT,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    SEG_USEG,
    SEG_KSEG0,
    SEG_KSEG1,
    SEG_KSEG23
  } seg_t;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_TLBL = 5'd2;

  localparam logic [1:0] REFTYPE_FETCH = 2'b00;
  localparam logic [1:0] REFTYPE_LOAD  = 2'b01;
  localparam logic [1:0] REFTYPE_STORE = 2'b10;

  function automatic seg_t seg_decode(input logic [31:0] va);
    seg_t s;
    if (!va[31]) begin
      s = SEG_USEG;
    end else begin
      case (va[30:29])
        2'b00:   s = SEG_KSEG0;
        2'b01:   s = SEG_KSEG1;
        default: s = SEG_KSEG23;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/ifetch_xlate.sv
// Fetch PC holder and address classifier in front of the iTLB: raises fetch
// exceptions, issues the physical I-cache request and hands bundles to decode.
module ifetch_xlate
  import mmu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        user_mode,
  output logic [31:0] tlb_vaddr,
  output logic [1:0]  tlb_reftype,
  input  logic [31:0] tlb_phy_addr,
  input  logic        tlb_refill,
  input  logic        tlb_invalid,
  output logic        ic_req,
  output logic [31:0] ic_paddr,
  output logic        ic_uncached,
  input  logic        ic_ack,
  input  logic        ic_rvalid,
  input  logic [31:0] ic_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_exc,
  output logic [4:0]  if_exccode,
  output logic        if_tlb_refill,
  output logic [31:0] if_badvaddr,
  input  logic        id_ready
);

  state_t      state;
  logic [31:0] pc;

  seg_t        seg;
  logic        xl_fault;
  logic [4:0]  xl_code;
  logic        xl_refill;
  logic [31:0] xl_paddr;
  logic        xl_uncached;
  logic        resp_pending;

  assign tlb_vaddr   = pc;
  assign tlb_reftype = REFTYPE_FETCH;

  // Translation of the current PC; only consumed while in XLATE.
  always_comb begin
    seg         = seg_decode(pc);
    xl_fault    = 1'b0;
    xl_code     = EXC_ADEL;
    xl_refill   = 1'b0;
    xl_paddr    = {3'b000, pc[28:0]};
    xl_uncached = (seg == SEG_KSEG1);
    if ((pc[1:0] != 2'b00) || (user_mode && pc[31])) begin
      xl_fault = 1'b1;
    end else if ((seg == SEG_USEG) || (seg == SEG_KSEG23)) begin
      xl_paddr    = tlb_phy_addr;
      xl_uncached = 1'b0;
      if (tlb_refill) begin
        xl_fault  = 1'b1;
        xl_code   = EXC_TLBL;
        xl_refill = 1'b1;
      end else if (tlb_invalid) begin
        xl_fault = 1'b1;
        xl_code  = EXC_TLBL;
      end
    end
  end

  // A cache response is still owed to us and must be swallowed after a redirect.
  assign resp_pending = ((state == RESP)  && !ic_rvalid) ||
                        ((state == REQ)   &&  ic_ack)    ||
                        ((state == DRAIN) && !ic_rvalid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= XLATE;
      pc            <= RESET_PC;
      ic_req        <= 1'b0;
      ic_paddr      <= '0;
      ic_uncached   <= 1'b0;
      if_valid      <= 1'b0;
      if_pc         <= '0;
      if_inst       <= '0;
      if_exc        <= 1'b0;
      if_exccode    <= '0;
      if_tlb_refill <= 1'b0;
      if_badvaddr   <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      ic_req   <= 1'b0;
      if_valid <= 1'b0;
      if_exc   <= 1'b0;
      state    <= resp_pending ? DRAIN : XLATE;
    end else begin
      case (state)
        XLATE: begin
          if (xl_fault) begin
            if_valid      <= 1'b1;
            if_exc        <= 1'b1;
            if_pc         <= pc;
            if_inst       <= '0;
            if_exccode    <= xl_code;
            if_tlb_refill <= xl_refill;
            if_badvaddr   <= pc;
            state         <= EXC;
          end else begin
            ic_req      <= 1'b1;
            ic_paddr    <= xl_paddr;
            ic_uncached <= xl_uncached;
            state       <= REQ;
          end
        end
        REQ: begin
          if (ic_ack) begin
            ic_req <= 1'b0;
            state  <= RESP;
          end
        end
        RESP: begin
          if (ic_rvalid) begin
            if_valid      <= 1'b1;
            if_exc        <= 1'b0;
            if_pc         <= pc;
            if_inst       <= ic_rdata;
            if_exccode    <= '0;
            if_tlb_refill <= 1'b0;
            state         <= OUT;
          end
        end
        OUT: begin
          if (id_ready) begin
            if_valid <= 1'b0;
            pc       <= pc + 32'd4;
            state    <= XLATE;
          end
        end
        EXC: begin
          if (id_ready) begin
            if_valid <= 1'b0;
            if_exc   <= 1'b0;
            state    <= HALT;
          end
        end
        HALT: state <= HALT;
        DRAIN: begin
          if (ic_rvalid) state <= XLATE;
        end
        default: state <= XLATE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_xlate.sv
// Directed bench for ifetch_xlate: hand-computed fetch, exception, redirect
// and reset scenarios against a manually driven I-cache and iTLB.
module tb_ifetch_xlate;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        user_mode;
  logic [31:0] tlb_vaddr;
  logic [1:0]  tlb_reftype;
  logic [31:0] tlb_phy_addr;
  logic        tlb_refill;
  logic        tlb_invalid;
  logic        ic_req;
  logic [31:0] ic_paddr;
  logic        ic_uncached;
  logic        ic_ack;
  logic        ic_rvalid;
  logic [31:0] ic_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_exc;
  logic [4:0]  if_exccode;
  logic        if_tlb_refill;
  logic [31:0] if_badvaddr;
  logic        id_ready;

  int checks = 0;
  int errors = 0;

  ifetch_xlate dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .user_mode     (user_mode),
    .tlb_vaddr     (tlb_vaddr),
    .tlb_reftype   (tlb_reftype),
    .tlb_phy_addr  (tlb_phy_addr),
    .tlb_refill    (tlb_refill),
    .tlb_invalid   (tlb_invalid),
    .ic_req        (ic_req),
    .ic_paddr      (ic_paddr),
    .ic_uncached   (ic_uncached),
    .ic_ack        (ic_ack),
    .ic_rvalid     (ic_rvalid),
    .ic_rdata      (ic_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_exc        (if_exc),
    .if_exccode    (if_exccode),
    .if_tlb_refill (if_tlb_refill),
    .if_badvaddr   (if_badvaddr),
    .id_ready      (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (ic_req !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", ic_req, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (if_valid !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("valid_seen", if_valid, 1);
  endtask

  task automatic respond(input logic [31:0] d);
    ic_ack = 1'b1;
    @(negedge clk);
    ic_ack    = 1'b0;
    ic_rvalid = 1'b1;
    ic_rdata  = d;
    @(negedge clk);
    ic_rvalid = 1'b0;
    wait_valid();
  endtask

  task automatic accept();
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    user_mode = 1'b0;
    tlb_phy_addr = '0;
    tlb_refill = 1'b0;
    tlb_invalid = 1'b0;
    ic_ack = 1'b0;
    ic_rvalid = 1'b0;
    ic_rdata = '0;
    id_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req", ic_req, 0);
    check("rst_valid", if_valid, 0);
    check("rst_exc", if_exc, 0);
    check("rst_exccode", if_exccode, 0);
    check("rst_paddr", ic_paddr, 0);
    check("rst_ifpc", if_pc, 0);
    check("rst_vaddr", tlb_vaddr, 32'hBFC0_0000);
    check("reftype", tlb_reftype, 0);
    rst = 1'b1;

    // Boot fetch from kseg1
    wait_req();
    check("boot_paddr", ic_paddr, 32'h1FC0_0000);
    check("boot_unc", ic_uncached, 1);
    respond(32'h2408_0001);
    check("boot_inst", if_inst, 32'h2408_0001);
    check("boot_pc", if_pc, 32'hBFC0_0000);
    check("boot_exc", if_exc, 0);
    accept();
    check("boot_next", tlb_vaddr, 32'hBFC0_0004);

    // kseg0 redirect and back-to-back fetches
    do_redirect(32'h8000_0100);
    check("redir_n1_req", ic_req, 0);
    @(negedge clk);
    check("redir_n2_req", ic_req, 1);
    for (int i = 0; i < 3; i++) begin
      wait_req();
      check("k0_paddr", ic_paddr, 32'h0000_0100 + 32'(i * 4));
      check("k0_unc", ic_uncached, 0);
      respond(32'h1000_0000 + 32'(i));
      check("k0_pc", if_pc, 32'h8000_0100 + 32'(i * 4));
      check("k0_inst", if_inst, 32'h1000_0000 + 32'(i));
      accept();
    end

    // Misaligned PC -> AdEL, then HALT
    do_redirect(32'h0040_0002);
    @(negedge clk);
    check("adel_valid", if_valid, 1);
    check("adel_exc", if_exc, 1);
    check("adel_code", if_exccode, 4);
    check("adel_bad", if_badvaddr, 32'h0040_0002);
    check("adel_refill", if_tlb_refill, 0);
    check("adel_inst", if_inst, 0);
    check("adel_noreq", ic_req, 0);
    accept();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_req", ic_req, 0);
      check("halt_valid", if_valid, 0);
    end
    do_redirect(32'hBFC0_0380);
    wait_req();
    check("vec_paddr", ic_paddr, 32'h1FC0_0380);
    respond(32'h0000_0000);
    check("vec_pc", if_pc, 32'hBFC0_0380);
    accept();

    // User-mode kernel access, TLB refill, TLB invalid, TLB hit
    user_mode = 1'b1;
    do_redirect(32'h8000_0000);
    @(negedge clk);
    check("um_exc", if_exc, 1);
    check("um_code", if_exccode, 4);
    check("um_bad", if_badvaddr, 32'h8000_0000);
    accept();
    user_mode = 1'b0;
    tlb_refill = 1'b1;
    do_redirect(32'h0040_0000);
    @(negedge clk);
    check("refill_exc", if_exc, 1);
    check("refill_code", if_exccode, 2);
    check("refill_flag", if_tlb_refill, 1);
    check("refill_bad", if_badvaddr, 32'h0040_0000);
    accept();
    tlb_refill = 1'b0;
    tlb_invalid = 1'b1;
    do_redirect(32'h0040_0004);
    @(negedge clk);
    check("inv_exc", if_exc, 1);
    check("inv_code", if_exccode, 2);
    check("inv_flag", if_tlb_refill, 0);
    check("inv_bad", if_badvaddr, 32'h0040_0004);
    accept();
    tlb_invalid = 1'b0;
    tlb_phy_addr = 32'h1234_5008;
    do_redirect(32'h0040_0008);
    check("hit_vaddr", tlb_vaddr, 32'h0040_0008);
    wait_req();
    check("hit_paddr", ic_paddr, 32'h1234_5008);
    check("hit_unc", ic_uncached, 0);
    respond(32'h0000_0005);
    check("hit_pc", if_pc, 32'h0040_0008);
    check("hit_exc", if_exc, 0);
    accept();

    // Redirect during RESP drains the stale response
    do_redirect(32'h8000_0200);
    wait_req();
    ic_ack = 1'b1;
    @(negedge clk);
    ic_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("drain_req0", ic_req, 0);
    @(negedge clk);
    check("drain_req1", ic_req, 0);
    ic_rvalid = 1'b1;
    ic_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    ic_rvalid = 1'b0;
    check("drain_valid", if_valid, 0);
    wait_req();
    check("drain_paddr", ic_paddr, 32'h0000_0300);
    respond(32'hAAAA_0000);
    check("drain_pc", if_pc, 32'h8000_0300);
    check("drain_inst", if_inst, 32'hAAAA_0000);
    accept();

    // Redirect coincident with rvalid: no drain
    do_redirect(32'h8000_0400);
    wait_req();
    ic_ack = 1'b1;
    @(negedge clk);
    ic_ack = 1'b0;
    ic_rvalid = 1'b1;
    ic_rdata = 32'hBBBB_0000;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0500;
    @(negedge clk);
    ic_rvalid = 1'b0;
    redirect_valid = 1'b0;
    check("nodrain_valid", if_valid, 0);
    @(negedge clk);
    check("nodrain_req", ic_req, 1);
    check("nodrain_paddr", ic_paddr, 32'h0000_0500);
    respond(32'hCCCC_0000);
    check("nodrain_pc", if_pc, 32'h8000_0500);
    accept();

    // Backpressure: bundle held stable, no new request
    do_redirect(32'h8000_0600);
    wait_req();
    respond(32'hDDDD_0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", if_valid, 1);
      check("hold_pc", if_pc, 32'h8000_0600);
      check("hold_inst", if_inst, 32'hDDDD_0001);
      check("hold_req", ic_req, 0);
    end
    accept();
    wait_req();
    check("hold_next", ic_paddr, 32'h0000_0604);
    respond(32'h0000_0001);
    // Redirect together with id_ready: no increment
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0700;
    @(negedge clk);
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    check("rdy_redir_valid", if_valid, 0);
    @(negedge clk);
    check("rdy_redir_req", ic_req, 1);
    check("rdy_redir_paddr", ic_paddr, 32'h0000_0700);

    // Asynchronous reset mid-REQ, late rvalid ignored afterwards
    rst = 1'b0;
    #1;
    check("arst_req", ic_req, 0);
    check("arst_valid", if_valid, 0);
    check("arst_paddr", ic_paddr, 0);
    check("arst_vaddr", tlb_vaddr, 32'hBFC0_0000);
    @(negedge clk);
    rst = 1'b1;
    ic_rvalid = 1'b1;
    ic_rdata = 32'h5555_5555;
    @(negedge clk);
    ic_rvalid = 1'b0;
    check("late_req", ic_req, 1);
    check("late_paddr", ic_paddr, 32'h1FC0_0000);
    check("late_valid", if_valid, 0);
    respond(32'h0000_0009);
    check("late_pc", if_pc, 32'hBFC0_0000);
    check("late_inst", if_inst, 32'h0000_0009);
    accept();

    // PC increment wraps at 32 bits
    tlb_phy_addr = 32'h0000_0FFC;
    do_redirect(32'hFFFF_FFFC);
    wait_req();
    check("wrap_paddr", ic_paddr, 32'h0000_0FFC);
    respond(32'h0000_0007);
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    accept();
    check("wrap_next", tlb_vaddr, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
